// File: rtl/train_pulse_seq_if.sv
// ---------------------------------------------------------------------------
// train_pulse_seq_if
// Bundles the control, configuration and status signals of the training
// pulse sequencer. clk and rst_n are kept as plain ports on the modules.
//   master : drives run enables, start and cfg_*; observes the state outputs
//   slave  : the sequencer side (train_pulse_seq)
// Signals:
//   key_state, system_state  run enable (active when key_state && state==2)
//   start                    one-cycle step request
//   cfg_ph_en, cfg_np1/2     phase enables and pulse counts
//   cfg_t_on/set/gap/read    timing durations in clock cycles
//   dac_top_state            sequencer state code
//   pulse18/28_state         per-polarity pulse sub-states
//   busy, done, pulse_cnt    status outputs
// ---------------------------------------------------------------------------
interface train_pulse_seq_if #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
);
  logic             key_state;
  logic [2:0]       system_state;
  logic             start;
  logic [1:0]       cfg_ph_en;
  logic [NP_W-1:0]  cfg_np1;
  logic [NP_W-1:0]  cfg_np2;
  logic [CNT_W-1:0] cfg_t_on;
  logic [CNT_W-1:0] cfg_t_set;
  logic [CNT_W-1:0] cfg_t_gap;
  logic [CNT_W-1:0] cfg_t_read;
  logic [3:0]       dac_top_state;
  logic [1:0]       pulse18_state;
  logic [1:0]       pulse28_state;
  logic             busy;
  logic             done;
  logic [NP_W-1:0]  pulse_cnt;

  modport master (
    output key_state, system_state, start, cfg_ph_en, cfg_np1, cfg_np2,
           cfg_t_on, cfg_t_set, cfg_t_gap, cfg_t_read,
    input  dac_top_state, pulse18_state, pulse28_state, busy, done, pulse_cnt
  );

  modport slave (
    input  key_state, system_state, start, cfg_ph_en, cfg_np1, cfg_np2,
           cfg_t_on, cfg_t_set, cfg_t_gap, cfg_t_read,
    output dac_top_state, pulse18_state, pulse28_state, busy, done, pulse_cnt
  );
endinterface

// File: rtl/train_pulse_seq.sv
// ---------------------------------------------------------------------------
// train_pulse_seq
// Training-step sequencer: a burst of phase-1 pulses, a burst of phase-2
// pulses, a read window, then a one-cycle completion. Each pulse walks
// V1_x (sub-states 1, 2 x t_on, 3) -> CNT_1_x (t_gap) -> V2_x (t_set) ->
// CNT_2_x (1 cycle, pulse count decrement). Durations of 0 act as 1.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    train_pulse_seq_if.slave (run enables, start, cfg_*, status)
// All outputs are registers; they are loaded from the next-state values so
// they line up with dac_top_state in the same cycle.
// ---------------------------------------------------------------------------
module train_pulse_seq #(
  parameter int CNT_W = 16,
  parameter int NP_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  train_pulse_seq_if.slave bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_V1_2     = 4'd1;
  localparam logic [3:0] S_CNT_1_2  = 4'd2;
  localparam logic [3:0] S_V2_2     = 4'd3;
  localparam logic [3:0] S_CNT_2_2  = 4'd4;
  localparam logic [3:0] S_V_READ   = 4'd5;
  localparam logic [3:0] S_COMPLETE = 4'd6;
  localparam logic [3:0] S_V1_1     = 4'd7;
  localparam logic [3:0] S_V2_1     = 4'd8;
  localparam logic [3:0] S_CNT_1_1  = 4'd9;
  localparam logic [3:0] S_CNT_2_1  = 4'd10;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NP_W-1:0]  NP_ONE  = {{(NP_W-1){1'b0}}, 1'b1};

  // A programmed duration of zero still occupies one cycle.
  function automatic logic [CNT_W-1:0] eff_dur(input logic [CNT_W-1:0] t);
    eff_dur = (t == {CNT_W{1'b0}}) ? CNT_ONE : t;
  endfunction

  logic [3:0]       state_q, state_d;
  logic [1:0]       sub_q, sub_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NP_W-1:0]  pcnt_q, pcnt_d;
  logic             latch_s;
  logic             run_s;

  // Shadow copies taken at step acceptance. Phase-1 count and enable are
  // consumed at acceptance (pulse_cnt load) and need no shadow.
  logic             en2_q;
  logic [NP_W-1:0]  np2_q;
  logic [CNT_W-1:0] t_on_q, t_set_q, t_gap_q, t_read_q;

  logic [1:0]       p18_q, p18_d, p28_q, p28_d;
  logic             busy_q, busy_d, done_q, done_d;

  assign run_s = bus.key_state && (bus.system_state == 3'd2);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sub_q   <= 2'd0;
      cnt_q   <= {CNT_W{1'b0}};
      pcnt_q  <= {NP_W{1'b0}};
      p18_q   <= 2'd0;
      p28_q   <= 2'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      p18_q   <= p18_d;
      p28_q   <= p28_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Configuration shadow registers, loaded when a step is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en2_q    <= 1'b0;
      np2_q    <= {NP_W{1'b0}};
      t_on_q   <= {CNT_W{1'b0}};
      t_set_q  <= {CNT_W{1'b0}};
      t_gap_q  <= {CNT_W{1'b0}};
      t_read_q <= {CNT_W{1'b0}};
    end else if (latch_s) begin
      en2_q    <= bus.cfg_ph_en[1];
      np2_q    <= bus.cfg_np2;
      t_on_q   <= bus.cfg_t_on;
      t_set_q  <= bus.cfg_t_set;
      t_gap_q  <= bus.cfg_t_gap;
      t_read_q <= bus.cfg_t_read;
    end else begin
      en2_q    <= en2_q;
      np2_q    <= np2_q;
      t_on_q   <= t_on_q;
      t_set_q  <= t_set_q;
      t_gap_q  <= t_gap_q;
      t_read_q <= t_read_q;
    end
  end

  // Next-state, counter and pulse-count logic.
  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    latch_s = 1'b0;
    if (!run_s) begin
      state_d = S_IDLE;
      sub_d   = 2'd0;
      cnt_d   = {CNT_W{1'b0}};
      pcnt_d  = {NP_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            latch_s = 1'b1;
            if (bus.cfg_ph_en[0] && (bus.cfg_np1 != {NP_W{1'b0}})) begin
              state_d = S_V1_1;
              sub_d   = 2'd1;
              pcnt_d  = bus.cfg_np1;
            end else if (bus.cfg_ph_en[1] && (bus.cfg_np2 != {NP_W{1'b0}})) begin
              state_d = S_V1_2;
              sub_d   = 2'd1;
              pcnt_d  = bus.cfg_np2;
            end else begin
              state_d = S_V_READ;
              sub_d   = 2'd0;
              cnt_d   = eff_dur(bus.cfg_t_read);
              pcnt_d  = {NP_W{1'b0}};
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_V1_1, S_V1_2: begin
          case (sub_q)
            2'd1: begin
              sub_d = 2'd2;
              cnt_d = eff_dur(t_on_q);
            end
            2'd2: begin
              if (cnt_q <= CNT_ONE) begin
                sub_d = 2'd3;
              end else begin
                cnt_d = cnt_q - CNT_ONE;
              end
            end
            2'd3: begin
              sub_d   = 2'd0;
              state_d = (state_q == S_V1_1) ? S_CNT_1_1 : S_CNT_1_2;
              cnt_d   = eff_dur(t_gap_q);
            end
            default: begin
              // sub-state 0 inside a pulse state is unreachable; abandon the step
              state_d = S_IDLE;
              sub_d   = 2'd0;
              cnt_d   = {CNT_W{1'b0}};
              pcnt_d  = {NP_W{1'b0}};
            end
          endcase
        end
        S_CNT_1_1, S_CNT_1_2: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = (state_q == S_CNT_1_1) ? S_V2_1 : S_V2_2;
            cnt_d   = eff_dur(t_set_q);
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_V2_1, S_V2_2: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = (state_q == S_V2_1) ? S_CNT_2_1 : S_CNT_2_2;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_CNT_2_1: begin
          pcnt_d = pcnt_q - NP_ONE;
          if (pcnt_q != NP_ONE) begin
            state_d = S_V1_1;
            sub_d   = 2'd1;
          end else if (en2_q && (np2_q != {NP_W{1'b0}})) begin
            state_d = S_V1_2;
            sub_d   = 2'd1;
            pcnt_d  = np2_q;
          end else begin
            state_d = S_V_READ;
            cnt_d   = eff_dur(t_read_q);
          end
        end
        S_CNT_2_2: begin
          pcnt_d = pcnt_q - NP_ONE;
          if (pcnt_q != NP_ONE) begin
            state_d = S_V1_2;
            sub_d   = 2'd1;
          end else begin
            state_d = S_V_READ;
            cnt_d   = eff_dur(t_read_q);
          end
        end
        S_V_READ: begin
          if (cnt_q <= CNT_ONE) begin
            state_d = S_COMPLETE;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_COMPLETE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          sub_d   = 2'd0;
          cnt_d   = {CNT_W{1'b0}};
          pcnt_d  = {NP_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode from the next state so registered outputs match state_q.
  always_comb begin
    p18_d  = (state_d == S_V1_1) ? sub_d : 2'd0;
    p28_d  = (state_d == S_V1_2) ? sub_d : 2'd0;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_COMPLETE);
  end

  assign bus.dac_top_state = state_q;
  assign bus.pulse18_state = p18_q;
  assign bus.pulse28_state = p28_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pulse_cnt     = pcnt_q;

endmodule
